// File: rtl/regfile_display.sv
// Register file (reg 0 hardwired to zero, async reads) with a registered display that is either loaded manually or scanned.
// Reads are zero latency and DISP/DISP_IDX update one edge after the cause; there is no backpressure. Optional REGFILE_DISPLAY_BYPASS_EN forwards write data to the read ports.
module regfile_display #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int SCAN_DIV = 25000000,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLOCK_50,
  input  logic             RESETn,
  input  logic             RFWrite,
  input  logic [AW-1:0]    regA,
  input  logic [AW-1:0]    regB,
  input  logic [AW-1:0]    regW,
  input  logic [WIDTH-1:0] dataW,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  input  logic             EN,
  input  logic             MODE,
  output logic [WIDTH-1:0] DISP,
  output logic [AW-1:0]    DISP_IDX
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int NA = 1 << AW;

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  logic [WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [WIDTH-1:0] rd_arr [NA];
  logic             wr_hit;
  logic             wr_en;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [AW-1:0]    idx_nxt;
  logic [WIDTH-1:0] disp_q, disp_d;

  // Full address space view: entry 0 and out-of-range entries read as zero.
  always_comb begin
    for (int i = 0; i < NA; i++) rd_arr[i] = '0;
    for (int i = 1; i < DEPTH; i++) rd_arr[i] = regs_q[i];
  end

  always_comb begin
    wr_hit = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      if (regW == AW'(i)) wr_hit = 1'b1;
    end
  end

  assign wr_en = RFWrite & wr_hit;

`ifdef REGFILE_DISPLAY_BYPASS_EN
  assign dataA = (wr_en && (regA == regW)) ? dataW : rd_arr[regA];
  assign dataB = (wr_en && (regB == regW)) ? dataW : rd_arr[regB];
`else
  assign dataA = rd_arr[regA];
  assign dataB = rd_arr[regB];
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!RESETn) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (RFWrite && (regW == AW'(i))) regs_q[i] <= dataW;
      end
    end
  end

  assign idx_nxt = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + AW'(1);

  // Scan loads read the array directly, so a same-cycle write shows up one refresh later.
  always_comb begin
    state_d = MODE ? SCAN : MANUAL;
    div_d   = div_q;
    idx_d   = idx_q;
    disp_d  = disp_q;
    case (state_q)
      MANUAL: begin
        if (MODE) begin
          div_d  = '0;
          idx_d  = '0;
          disp_d = rd_arr[0];
        end else if (EN) begin
          disp_d = dataA;
        end
      end
      SCAN: begin
        if (!MODE) begin
          div_d = '0;
        end else if (div_q == DW'(SCAN_DIV - 1)) begin
          div_d  = '0;
          idx_d  = idx_nxt;
          disp_d = rd_arr[idx_nxt];
        end else begin
          div_d  = div_q + DW'(1);
          disp_d = rd_arr[idx_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETn) begin
      state_q <= MANUAL;
      div_q   <= '0;
      idx_q   <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      disp_q  <= disp_d;
    end
  end

  assign DISP     = disp_q;
  assign DISP_IDX = idx_q;

endmodule

// File: tb/tb_regfile_display.sv
// Directed and random stimulus for regfile_display against a cycle-count based reference model.
module tb_regfile_display;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int SD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rstn, wr, en, mode;
  logic [AW-1:0] ra, rb, rw;
  logic [W-1:0]  dw;
  logic [W-1:0]  da, db, disp;
  logic [AW-1:0] didx;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_reg [D];
  logic [W-1:0] m_disp;
  int           m_idx;
  bit           m_scan;
  int           m_cnt;
  int           guard;

  always #5 clk = ~clk;

  regfile_display #(.WIDTH(W), .DEPTH(D), .SCAN_DIV(SD)) dut (
    .CLOCK_50(clk), .RESETn(rstn), .RFWrite(wr),
    .regA(ra), .regB(rb), .regW(rw), .dataW(dw),
    .dataA(da), .dataB(db), .EN(en), .MODE(mode),
    .DISP(disp), .DISP_IDX(didx)
  );

  function automatic logic [W-1:0] rd(input logic [AW-1:0] a);
    return (a == 0) ? '0 : m_reg[a];
  endfunction

  function automatic logic [W-1:0] rd_port(input logic [AW-1:0] a);
`ifdef REGFILE_DISPLAY_BYPASS_EN
    if (wr && rw != 0 && a == rw) return dw;
`endif
    return rd(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check reads, advance the model from pre-edge values, check display.
  task automatic step();
    #2;
    chk("dataA", {24'b0, da}, {24'b0, rd_port(ra)});
    chk("dataB", {24'b0, db}, {24'b0, rd_port(rb)});
    if (!rstn) begin
      for (int i = 0; i < D; i++) m_reg[i] = '0;
      m_disp = '0; m_idx = 0; m_scan = 0; m_cnt = 0;
    end else begin
      if (mode) begin
        m_cnt  = m_scan ? m_cnt + 1 : 0;
        m_idx  = (m_cnt / SD) % D;
        m_disp = rd(AW'(m_idx));
        m_scan = 1;
      end else if (m_scan) begin
        m_scan = 0;
      end else if (en) begin
        m_disp = rd_port(ra);
      end
      if (wr && rw != 0) m_reg[rw] = dw;
    end
    @(posedge clk);
    #1;
    chk("DISP", {24'b0, disp}, {24'b0, m_disp});
    chk("DISP_IDX", {30'b0, didx}, m_idx);
  endtask

  initial begin
    rstn = 1'b0; wr = 1'b0; en = 1'b0; mode = 1'b0;
    ra = '0; rb = '0; rw = '0; dw = '0;
    for (int i = 0; i < D; i++) m_reg[i] = 'x;
    m_disp = 'x; m_idx = 0; m_scan = 0; m_cnt = 0;
    step();
    chk("reset_disp", {24'b0, disp}, 32'h0);

    rstn = 1'b1;
    wr = 1'b1; rw = 2'd2; dw = 8'h5A; ra = 2'd2; rb = 2'd0;
    step();
    wr = 1'b0;
    #2;
    chk("rd_5a", {24'b0, da}, 32'h5A);
    chk("rd_r0", {24'b0, db}, 32'h0);
    step();

    wr = 1'b1; rw = 2'd0; dw = 8'hFF;
    step();
    wr = 1'b0; ra = 2'd0;
    #2;
    chk("rd_r0_after_wr", {24'b0, da}, 32'h0);
    step();

    wr = 1'b1; rw = 2'd3; dw = 8'h11;
    step();
    ra = 2'd3; dw = 8'h3C;
    #2;
`ifdef REGFILE_DISPLAY_BYPASS_EN
    chk("bypass", {24'b0, da}, 32'h3C);
`else
    chk("no_bypass", {24'b0, da}, 32'h11);
`endif
    step();

    rw = 2'd1; dw = 8'h77;
    step();
    wr = 1'b0; ra = 2'd1; en = 1'b1;
    step();
    chk("manual_load", {24'b0, disp}, 32'h77);
    en = 1'b0; wr = 1'b1; dw = 8'h99;
    step();
    wr = 1'b0;
    step();
    chk("manual_hold", {24'b0, disp}, 32'h77);

    for (int i = 1; i < D; i++) begin
      wr = 1'b1; rw = AW'(i); dw = W'(i);
      step();
    end
    wr = 1'b0; mode = 1'b1;
    for (int i = 0; i < 22; i++) step();

    guard = 0;
    while (m_idx != 2 && guard < 40) begin
      step();
      guard++;
    end
    chk("reach_idx2", {30'b0, didx}, 32'd2);
    rstn = 1'b0; wr = 1'b1; rw = 2'd3; dw = 8'hAB;
    step();
    chk("rst_disp", {24'b0, disp}, 32'h0);
    chk("rst_idx", {30'b0, didx}, 32'h0);
    rstn = 1'b1; wr = 1'b0; ra = 2'd3; rb = 2'd2;
    for (int i = 0; i < 10; i++) step();

    mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rstn = ($urandom_range(99) != 0);
      wr   = 1'($urandom);
      en   = 1'($urandom);
      ra   = AW'($urandom);
      rb   = AW'($urandom);
      rw   = AW'($urandom);
      dw   = W'($urandom);
      if ($urandom_range(15) == 0) mode = ~mode;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
